uart_rx_frame: RTL
==================

Name: uart_rx_frame

Overview:
- UART receiver that consumes the 16x-oversampling tick from the baud-rate tick counter and deserialises 8N1 frames from the serial input.
- Sits directly downstream of the baud tick generator. Feeds received bytes to the FPU command/operand loader.
- Resynchronises rx, rejects start-bit glitches, flags framing errors, and handles line-break (rx held low).

Parameters:
- DBIT, 8, number of data bits per frame, sent LSB first.
- SB_TICK, 16, oversampling ticks spent in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- OS, 16, oversampling ticks per bit. Must match the tick generator rate.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  reset; asynchronous, active-low.
- s_tick  in  1  oversampling tick: one clk-wide pulse, OS pulses per bit period.
- rx  in  1  serial line, asynchronous to clk, idle high.
- dout  out  DBIT  last received data byte.
- rx_done_tick  out  1  one-clk pulse: dout holds a valid frame.
- frame_err_tick  out  1  one-clk pulse: stop bit sampled low.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; tick counter s=0; bit counter n=0; shift register b=0.
  - dout=0, rx_done_tick=0, frame_err_tick=0, busy=0.
  - rx synchroniser flops preset to 1.
- Reset mid-frame aborts the frame. No pulse is emitted.
- rx passes through a 2-flop synchroniser; rx_s is the synchronised value. All decisions below use rx_s, so rx has 2 clk of latency.
- Counter widths: s is ceil(log2(max(OS,SB_TICK))) bits; n is ceil(log2(DBIT)) bits. Neither counter may wrap inside a state.
- Counters advance only on clk edges where s_tick=1. Cycles without a tick leave s, n and b unchanged, in every state.
- States:
  - IDLE: when rx_s=0, go to START and set s=0. The tick is not required to start.
  - START: on each tick, s++. When s=OS/2-1 on a tick (mid start bit):
    - rx_s=0: go to DATA, s=0, n=0.
    - rx_s=1: glitch; go to IDLE. No pulse is emitted.
  - DATA: on each tick, s++. When s=OS-1 on a tick:
    - b = {rx_s, b[DBIT-1:1]} (LSB first), s=0.
    - If n=DBIT-1, go to STOP; otherwise n++.
  - STOP: on each tick, s++. When s=SB_TICK-1 on a tick:
    - dout<=b.
    - rx_s=1: rx_done_tick=1 for that one clk, then go to IDLE.
    - rx_s=0: frame_err_tick=1 for that one clk, rx_done_tick stays 0, then go to BREAK.
  - BREAK: wait until rx_s=1, then go to IDLE. This stops a held-low line from retriggering frames.
- Output timing:
  - Pulses are registered outputs, asserted the clk after the deciding tick.
  - dout updates in the same cycle as the pulse and holds until the next frame completes.
- rx_done_tick and frame_err_tick are never high together.
- busy = (state != IDLE).
- rx changes while s_tick=0 are only observed at the next tick-sampled decision point.

Test Plan:
1. s_tick every clk; send 0x55 as 8N1 with 16 clk/bit -> rx_done_tick exactly one pulse, dout=0x55, frame_err_tick=0, busy falls after the pulse.
2. s_tick every 4 clk; send back-to-back frames 0xA3 then 0x0F, no idle gap -> two rx_done_ticks 160 ticks apart, dout=0xA3 then 0x0F.
3. rx low for 4 ticks then high (glitch) -> returns to IDLE at tick 7, no pulses, dout unchanged.
4. Frame 0x81 with stop bit forced low, then line held low for 40 ticks -> frame_err_tick one pulse, dout=0x81, no rx_done_tick, stays in BREAK until rx high, next valid frame 0x3C received correctly.
5. Assert reset during DATA bit 4 of frame 0xFF -> all outputs 0 immediately, no pulse; next frame 0x12 received as 0x12.
6. SB_TICK=32 build; stop bit lasts 32 ticks -> rx_done_tick asserted 32 ticks after last data sample; rx low at tick 20 of stop has no effect.

Source files
------------

// File: rtl/uart_rx_frame_if.sv
// Byte-stream interface between the UART receiver and its neighbours:
// the oversampling tick and serial line come in, received bytes and
// status pulses go out.
interface uart_rx_frame_if #(
  parameter int DBIT = 8
);
  logic            s_tick;
  logic            rx;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            frame_err_tick;
  logic            busy;

  // Upstream side: tick generator and line driver, consumer of bytes.
  modport master (
    output s_tick, rx,
    input  dout, rx_done_tick, frame_err_tick, busy
  );

  // Receiver side.
  modport slave (
    input  s_tick, rx,
    output dout, rx_done_tick, frame_err_tick, busy
  );
endinterface

// File: rtl/uart_rx_frame.sv
// 8N1-style UART receiver driven by a 16x oversampling tick. The serial
// line is resynchronised, start bits are confirmed at mid-bit to reject
// glitches, a low stop bit raises a framing error, and a line held low
// after such an error is parked in BREAK until it returns high.
module uart_rx_frame #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int OS      = 16
) (
  input  logic          clk,
  input  logic          reset,
  uart_rx_frame_if.slave bus
);

  localparam int S_MAX = (OS > SB_TICK) ? OS : SB_TICK;
  localparam int S_W   = (S_MAX > 1) ? $clog2(S_MAX) : 1;
  localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

  // Terminal counts: mid start bit, end of a data bit, end of the stop window.
  localparam logic [S_W-1:0] S_MID  = S_W'(OS / 2 - 1);
  localparam logic [S_W-1:0] S_BIT  = S_W'(OS - 1);
  localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t          state;
  logic [S_W-1:0]  s;
  logic [N_W-1:0]  n;
  logic [DBIT-1:0] b;
  logic [DBIT-1:0] dout_r;
  logic            done_r;
  logic            ferr_r;
  logic            rx_p0;
  logic            rx_p1;
  logic            rx_s;

  // Two-flop synchroniser for the asynchronous line; presets to idle-high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= bus.rx;
      rx_p1 <= rx_p0;
    end
  end

  assign rx_s = rx_p1;

  // Frame state machine: counters only move on oversampling ticks, and the
  // status pulses are registered so they line up with the dout update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      s      <= '0;
      n      <= '0;
      b      <= '0;
      dout_r <= '0;
      done_r <= 1'b0;
      ferr_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      ferr_r <= 1'b0;
      case (state)
        IDLE: begin
          // Falling edge on the line starts a frame without waiting for a tick.
          if (!rx_s) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (bus.s_tick) begin
            if (s == S_MID) begin
              // Still low at mid start bit: a real start; otherwise a glitch.
              if (!rx_s) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        DATA: begin
          if (bus.s_tick) begin
            if (s == S_BIT) begin
              b <= {rx_s, b[DBIT-1:1]};
              s <= '0;
              if (n == N_LAST) begin
                state <= STOP;
              end else begin
                n <= n + 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        STOP: begin
          if (bus.s_tick) begin
            if (s == S_STOP) begin
              dout_r <= b;
              s      <= '0;
              if (rx_s) begin
                done_r <= 1'b1;
                state  <= IDLE;
              end else begin
                ferr_r <= 1'b1;
                state  <= BREAK;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        BREAK: begin
          // Hold off until the line is released so a stuck-low line
          // cannot retrigger a stream of bogus frames.
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.dout           = dout_r;
  assign bus.rx_done_tick   = done_r;
  assign bus.frame_err_tick = ferr_r;
  assign bus.busy           = (state != IDLE);

endmodule
